// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded control sequencer with stall, halt and bus-conflict suppression
module control_sequencer #(
   parameter int                     CW_WIDTH      = 32,
   parameter int                     OPCODE_WIDTH  = 8,
   parameter int                     STEP_BITS     = 3,
   parameter int                     END_BIT       = 31,
   parameter int                     HALT_BIT      = 30,
   parameter logic [CW_WIDTH-1:0]    DATA_BUS_MASK = 32'h18009112,
   parameter logic [CW_WIDTH-1:0]    ADDR_BUS_MASK = 32'h04000888
) (
   input  logic                              CLOCK,
   input  logic                              RESET,
   input  logic [OPCODE_WIDTH-1:0]           OPCODE,
   input  logic                              STALL,
   input  logic                              RESUME,
   input  logic [CW_WIDTH-1:0]               MICRO_WORD,
   output logic [OPCODE_WIDTH+STEP_BITS-1:0] MICRO_ADDR,
   output logic [CW_WIDTH-1:0]               CONTROL_LINES,
   output logic [STEP_BITS-1:0]              STEP,
   output logic                              HALTED,
   output logic                              BUS_CONFLICT,
   output logic                              STEP_OVERFLOW
);

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   localparam logic [STEP_BITS-1:0] STEP_MAX = '1;

   state_t               state_q, state_d;
   logic [STEP_BITS-1:0] step_q, step_d;
   logic [CW_WIDTH-1:0]  cl_q, cl_d;
   logic                 conflict_q, conflict_d;
   logic                 ovf_q, ovf_d;

   logic [CW_WIDTH-1:0]  data_masked, addr_masked, filtered_word;
   logic                 data_multi, addr_multi;

   // x & (x-1) is nonzero exactly when x has two or more bits set
   assign data_masked   = MICRO_WORD & DATA_BUS_MASK;
   assign addr_masked   = MICRO_WORD & ADDR_BUS_MASK;
   assign data_multi    = |(data_masked & (data_masked - CW_WIDTH'(1)));
   assign addr_multi    = |(addr_masked & (addr_masked - CW_WIDTH'(1)));
   assign filtered_word = MICRO_WORD
                        & ~(data_multi ? DATA_BUS_MASK : '0)
                        & ~(addr_multi ? ADDR_BUS_MASK : '0);

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      cl_d       = '0;
      conflict_d = conflict_q;
      ovf_d      = ovf_q;
      case (state_q)
         ST_RUN: begin
            if (!STALL) begin
               cl_d = filtered_word;
               if (data_multi || addr_multi) conflict_d = 1'b1;
               if (MICRO_WORD[HALT_BIT]) begin
                  step_d  = '0;
                  state_d = ST_HALT;
               end else if (MICRO_WORD[END_BIT]) begin
                  step_d = '0;
               end else begin
                  step_d = step_q + STEP_BITS'(1);
                  if (step_q == STEP_MAX) ovf_d = 1'b1;
               end
            end
         end
         ST_HALT: begin
            step_d = '0;
            if (RESUME && !STALL) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q    <= ST_RUN;
         step_q     <= '0;
         cl_q       <= '0;
         conflict_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         cl_q       <= cl_d;
         conflict_q <= conflict_d;
         ovf_q      <= ovf_d;
      end
   end

   assign MICRO_ADDR    = {OPCODE, step_q};
   assign CONTROL_LINES = cl_q;
   assign STEP          = step_q;
   assign HALTED        = (state_q == ST_HALT);
   assign BUS_CONFLICT  = conflict_q;
   assign STEP_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic [7:0]  OPCODE;
   logic        STALL;
   logic        RESUME;
   logic [31:0] MICRO_WORD;
   logic [10:0] MICRO_ADDR;
   logic [31:0] CONTROL_LINES;
   logic [2:0]  STEP;
   logic        HALTED;
   logic        BUS_CONFLICT;
   logic        STEP_OVERFLOW;

   int n_checks = 0;
   int n_errors = 0;

   control_sequencer dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .OPCODE       (OPCODE),
      .STALL        (STALL),
      .RESUME       (RESUME),
      .MICRO_WORD   (MICRO_WORD),
      .MICRO_ADDR   (MICRO_ADDR),
      .CONTROL_LINES(CONTROL_LINES),
      .STEP         (STEP),
      .HALTED       (HALTED),
      .BUS_CONFLICT (BUS_CONFLICT),
      .STEP_OVERFLOW(STEP_OVERFLOW)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] cl, input logic [2:0] st,
                             input logic hl, input logic bc, input logic ov);
      check({tag, ".cl"}, CONTROL_LINES, cl);
      check({tag, ".step"}, 32'(STEP), 32'(st));
      check({tag, ".halted"}, 32'(HALTED), 32'(hl));
      check({tag, ".bus_conflict"}, 32'(BUS_CONFLICT), 32'(bc));
      check({tag, ".step_overflow"}, 32'(STEP_OVERFLOW), 32'(ov));
   endtask

   initial begin
      RESET = 1'b1; OPCODE = 8'h05; STALL = 1'b0; RESUME = 1'b0; MICRO_WORD = 32'h0;
      tick(); tick();
      expect_out("reset", 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("reset.addr", 32'(MICRO_ADDR), 32'h028);
      RESET = 1'b0;

      // Fetch-execute over three steps
      MICRO_WORD = 32'h00004840; check("fe.addr0", 32'(MICRO_ADDR), 32'h028);
      tick(); expect_out("fe1", 32'h00004840, 3'd1, 1'b0, 1'b0, 1'b0);
      check("fe.addr1", 32'(MICRO_ADDR), 32'h029);
      MICRO_WORD = 32'h00000020;
      tick(); expect_out("fe2", 32'h00000020, 3'd2, 1'b0, 1'b0, 1'b0);
      check("fe.addr2", 32'(MICRO_ADDR), 32'h02A);
      MICRO_WORD = 32'h80010000;
      tick(); expect_out("fe3", 32'h80010000, 3'd0, 1'b0, 1'b0, 1'b0);

      // Stall two cycles at step 1
      MICRO_WORD = 32'h00004840; tick();
      STALL = 1'b1; MICRO_WORD = 32'h00000020;
      tick(); expect_out("stall1", 32'h0, 3'd1, 1'b0, 1'b0, 1'b0);
      tick(); expect_out("stall2", 32'h0, 3'd1, 1'b0, 1'b0, 1'b0);
      STALL = 1'b0;
      tick(); expect_out("unstall", 32'h00000020, 3'd2, 1'b0, 1'b0, 1'b0);
      MICRO_WORD = 32'h80000000;
      tick(); expect_out("endstep", 32'h80000000, 3'd0, 1'b0, 1'b0, 1'b0);

      // Bus conflicts: data field, sticky, then address field
      MICRO_WORD = 32'h08008040;
      tick(); expect_out("dconf", 32'h00000040, 3'd1, 1'b0, 1'b1, 1'b0);
      MICRO_WORD = 32'h80000001;
      tick(); expect_out("sticky", 32'h80000001, 3'd0, 1'b0, 1'b1, 1'b0);
      MICRO_WORD = 32'h04000818;
      tick(); expect_out("aconf", 32'h00000010, 3'd1, 1'b0, 1'b1, 1'b0);
      MICRO_WORD = 32'h80000000; tick();

      // Halt, resume ignored under stall, then resume
      MICRO_WORD = 32'h40000000;
      tick(); expect_out("halt", 32'h40000000, 3'd0, 1'b1, 1'b1, 1'b0);
      MICRO_WORD = 32'hFFFFFFFF;
      tick(); expect_out("halt_hold", 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
      RESUME = 1'b1; STALL = 1'b1;
      tick(); expect_out("resume_stalled", 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
      STALL = 1'b0;
      tick(); expect_out("resume", 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      RESUME = 1'b0; MICRO_WORD = 32'h00000020;
      tick(); expect_out("post_resume", 32'h00000020, 3'd1, 1'b0, 1'b1, 1'b0);
      MICRO_WORD = 32'h80000000; tick();

      // Eight words without END_BIT wrap the step counter; RESUME in RUN is ignored
      MICRO_WORD = 32'h00000020; RESUME = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      expect_out("pre_wrap", 32'h00000020, 3'd7, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("wrap", 32'h00000020, 3'd0, 1'b0, 1'b1, 1'b1);
      RESUME = 1'b0;

      // Reset at step 2 in RUN, with stall and resume asserted
      tick(); tick();
      check("pre_rst.step", 32'(STEP), 32'd2);
      RESET = 1'b1; STALL = 1'b1; RESUME = 1'b1; MICRO_WORD = 32'hFFFFFFFF;
      tick(); expect_out("rst_run", 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      RESET = 1'b0; STALL = 1'b0; RESUME = 1'b0;

      // Set conflict again, halt via HALT+END, then reset while halted
      MICRO_WORD = 32'h08008040; tick();
      MICRO_WORD = 32'hC0000000;
      tick(); expect_out("halt_end", 32'hC0000000, 3'd0, 1'b1, 1'b1, 1'b0);
      RESET = 1'b1; STALL = 1'b1; RESUME = 1'b1; MICRO_WORD = 32'hFFFFFFFF;
      tick(); expect_out("rst_halt", 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      RESET = 1'b0; STALL = 1'b0; RESUME = 1'b0; MICRO_WORD = 32'h00004840;
      check("rst.addr", 32'(MICRO_ADDR), 32'h028);
      tick(); expect_out("after_rst", 32'h00004840, 3'd1, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
